lfsr_6_ctrl: RTL and testbench

Sequencing controller for the 6-bit LFSR (`lfsr_6`, x^6+x^5+1, period 63). It accepts a seed and a step count from a requester, loads the LFSR, and streams successive LFSR states to a consumer over a valid/ready handshake. It stalls the LFSR under back-pressure by reloading its current value, and flags illegal seeds and sequence wrap-around. It sits between a configuration requester and a pseudo-random data consumer.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_6.sv | 23 ++
 rtl/lfsr_6_ctrl.sv | 122 ++++++++++++
 tb/tb_lfsr_6_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the 6-bit LFSR and its sequencing controller.
package lfsr_pkg;

    localparam int LFSR_W = 6;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 6'b110000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

    // Successor of v: shift left, feedback is the XOR of the tapped bits (x^6+x^5+1).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_6.sv
// 6-bit Fibonacci LFSR with parallel load; sel=1 loads p, sel=0 advances.
module lfsr_6
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic [LFSR_W-1:0] p,
    output logic [LFSR_W-1:0] out
);

    // LFSR state register: load or advance every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 6'b000000;
        end else if (sel) begin
            out <= p;
        end else begin
            out <= lfsr_next(out);
        end
    end

endmodule

// File: rtl/lfsr_6_ctrl.sv
// Sequencing controller: loads a seed into lfsr_6 and streams n_steps states over valid/ready.
module lfsr_6_ctrl
    import lfsr_pkg::*;
#(
    parameter int CNT_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    input  logic [CNT_W-1:0]  n_steps,
    output logic              busy,
    output logic [LFSR_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              done,
    output logic              err,
    output logic              wrapped
);

    ctrl_state_t       state_r;
    ctrl_state_t       state_nxt_s;
    logic [LFSR_W-1:0] seed_r;
    logic [CNT_W-1:0]  nsteps_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              wrapped_r;
    logic              err_r;
    logic              sel_s;
    logic [LFSR_W-1:0] p_s;
    logic [LFSR_W-1:0] lfsr_out_s;
    logic              xfer_s;
    logic              accept_s;

    assign xfer_s   = (state_r == RUN) && data_ready;
    assign accept_s = (state_r == IDLE) && start && (seed != 6'b000000);

    lfsr_6 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel_s),
        .p     (p_s),
        .out   (lfsr_out_s)
    );

    // Next-state and LFSR control; a stall reloads the current value to freeze data.
    always_comb begin
        state_nxt_s = state_r;
        sel_s       = 1'b0;
        p_s         = lfsr_out_s;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                sel_s = 1'b1;
                p_s   = seed_r;
                if (nsteps_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RUN: begin
                if (xfer_s) begin
                    sel_s = 1'b0;
                    if ((cnt_r + CNT_W'(1)) == nsteps_r) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    sel_s = 1'b1;
                    p_s   = lfsr_out_s;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control registers: state, captured run parameters, transfer counter, flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            seed_r    <= 6'b000000;
            nsteps_r  <= {CNT_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            wrapped_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            err_r   <= (state_r == IDLE) && start && (seed == 6'b000000);
            if (accept_s) begin
                seed_r    <= seed;
                nsteps_r  <= n_steps;
                cnt_r     <= {CNT_W{1'b0}};
                wrapped_r <= 1'b0;
            end else if (xfer_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
                if (lfsr_next(lfsr_out_s) == seed_r) begin
                    wrapped_r <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state_r != IDLE);
    assign data       = lfsr_out_s;
    assign data_valid = (state_r == RUN);
    assign done       = (state_r == DONE);
    assign err        = err_r;
    assign wrapped    = wrapped_r;

endmodule

// File: tb/tb_lfsr_6_ctrl.sv
// Directed self-checking bench for lfsr_6_ctrl with hand-computed LFSR sequences.
module tb_lfsr_6_ctrl;

    localparam int CNT_W = 7;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [5:0]       seed;
    logic [CNT_W-1:0] n_steps;
    logic             busy;
    logic [5:0]       data;
    logic             data_valid;
    logic             data_ready;
    logic             done;
    logic             err;
    logic             wrapped;

    int checks = 0;
    int errors = 0;

    lfsr_6_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .n_steps    (n_steps),
        .busy       (busy),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .done       (done),
        .err        (err),
        .wrapped    (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ref_next(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

    task automatic issue_start(input logic [5:0] s, input logic [CNT_W-1:0] n);
        start   = 1'b1;
        seed    = s;
        n_steps = n;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; seed = 6'd0; n_steps = 7'd0; data_ready = 1'b1;
        repeat (2) step();
        checks++;
        if ({busy, data_valid, done, err, wrapped} !== 5'b00000 || data !== 6'd0) begin
            errors++;
            $display("FAIL reset: got busy%b valid%b done%b err%b wrap%b data=%b, expected all 0",
                     busy, data_valid, done, err, wrapped, data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic(input logic pulse_start_mid);
        logic [5:0] exp_seq [4];
        exp_seq[0] = 6'b101011; exp_seq[1] = 6'b010111;
        exp_seq[2] = 6'b101111; exp_seq[3] = 6'b011111;
        data_ready = 1'b1;
        issue_start(6'b101011, 7'd4);
        checks++;
        if (busy !== 1'b1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_load: got busy=%b valid=%b, expected 1 0", busy, data_valid);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_valid !== 1'b1 || data !== exp_seq[i]) begin
                errors++;
                $display("FAIL basic_xfer%0d: got valid=%b data=%b, expected 1 %b", i, data_valid, data, exp_seq[i]);
            end
            if (pulse_start_mid && i == 1) begin
                start = 1'b1; seed = 6'b000111; n_steps = 7'd2;
            end else begin
                start = 1'b0;
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || data_valid !== 1'b0 || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b valid=%b wrap=%b, expected 1 1 0 0", done, busy, data_valid, wrapped);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_back_pressure();
        data_ready = 1'b1;
        issue_start(6'b101011, 7'd4);
        step();
        checks++;
        if (data !== 6'b101011 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: got data=%b valid=%b, expected 101011 1", data, data_valid);
        end
        step();
        data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data !== 6'b010111 || data_valid !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got data=%b valid=%b done=%b, expected 010111 1 0", i, data, data_valid, done);
            end
            step();
        end
        data_ready = 1'b1;
        checks++;
        if (data !== 6'b010111) begin
            errors++;
            $display("FAIL bp_resume: got data=%b, expected 010111", data);
        end
        step();
        checks++;
        if (data !== 6'b101111) begin
            errors++;
            $display("FAIL bp_third: got data=%b, expected 101111", data);
        end
        step();
        checks++;
        if (data !== 6'b011111 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_fourth: got data=%b valid=%b, expected 011111 1", data, data_valid);
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: got done=%b, expected 1", done);
        end
        step();
    endtask

    task automatic test_zero_seed();
        issue_start(6'b000000, 7'd4);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_seed: got err=%b busy=%b valid=%b, expected 1 0 0", err, busy, data_valid);
        end
        step();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_seed_after: got err=%b busy=%b valid=%b, expected 0 0 0", err, busy, data_valid);
        end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_d;
        data_ready = 1'b1;
        issue_start(6'b000001, 7'd64);
        step();
        exp_d = 6'b000001;
        for (int k = 1; k <= 64; k++) begin
            checks++;
            if (data_valid !== 1'b1 || data !== exp_d) begin
                errors++;
                $display("FAIL wrap_xfer%0d: got valid=%b data=%b, expected 1 %b", k, data_valid, data, exp_d);
            end
            if (k == 63) begin
                checks++;
                if (wrapped !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_early: got wrapped=%b, expected 0", wrapped);
                end
            end
            if (k == 64) begin
                checks++;
                if (data !== 6'b000001) begin
                    errors++;
                    $display("FAIL wrap_return: got data=%b, expected 000001", data);
                end
            end
            exp_d = ref_next(exp_d);
            step();
        end
        checks++;
        if (done !== 1'b1 || wrapped !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: got done=%b wrapped=%b, expected 1 1", done, wrapped);
        end
        step();
        issue_start(6'b101011, 7'd0);
        checks++;
        if (wrapped !== 1'b0) begin
            errors++;
            $display("FAIL wrap_clear: got wrapped=%b, expected 0", wrapped);
        end
        step();
        step();
    endtask

    task automatic test_zero_steps();
        issue_start(6'b101011, 7'd0);
        checks++;
        if (busy !== 1'b1 || data_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zsteps_load: got busy=%b valid=%b done=%b, expected 1 0 0", busy, data_valid, done);
        end
        step();
        checks++;
        if (done !== 1'b1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL zsteps_done: got done=%b valid=%b, expected 1 0", done, data_valid);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zsteps_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        data_ready = 1'b1;
        issue_start(6'b101011, 7'd4);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, data_valid, done, err, wrapped} !== 5'b00000 || data !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset: got busy%b valid%b done%b err%b wrap%b data=%b, expected all 0",
                     busy, data_valid, done, err, wrapped, data);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: got done=%b busy=%b, expected 0 0", done, busy);
        end
        rst_n = 1'b1;
        step();
        test_basic(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_back_pressure();
        test_zero_seed();
        test_wrap();
        test_zero_steps();
        test_basic(1'b1);
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
